sr_arbiter: RTL and testbench

SR_ARBITER -- requirements
Module: sr_arbiter

---
 rtl/sr_defs.sv | 24 ++
 rtl/sr_arbiter_rr_arb2.sv | 26 ++
 rtl/sr_arbiter.sv | 144 ++++++++++++++
 tb/tb_sr_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_defs.sv
// Shared definitions for the shift-register control blocks.
//   sr_state_e  : frame sequencer states
//   src_vec_t   : per-source vector (requests, grants, done pulses)
//   src_onehot  : source index -> one-hot source vector
package sr_defs;

  localparam int SRC_N = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_WAIT,
    ST_LATCH,
    ST_GAP
  } sr_state_e;

  typedef logic [SRC_N-1:0] src_vec_t;

  function automatic src_vec_t src_onehot(input logic idx);
    return idx ? src_vec_t'(2'b10) : src_vec_t'(2'b01);
  endfunction

endpackage

// File: rtl/sr_arbiter_rr_arb2.sv
// Two-way round-robin selector (purely combinational).
//   req  : request per source
//   last : index of the source served most recently
//   gnt  : one-hot winner, zero when nobody requests
import sr_defs::*;

module rr_arb2 (
  input  src_vec_t req,
  input  logic     last,
  output src_vec_t gnt
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie the source that was not served last takes the turn.
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/sr_arbiter.sv
// Frame arbiter for a shared shift register. Two sources request frames of
// up to 2^LENW words; the winner's words are loaded one at a time, each load
// waiting for the shift register to finish, then the output latch is strobed
// and the source gets a done pulse. GAP idle cycles follow every latch.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_req[1:0]         : level frame request per source
//   i_len0, i_len1     : frame length per source (L means L+1 words)
//   i_srbusy           : shift register is busy shifting
//   o_gnt[1:0]         : one-hot grant, held for the whole frame
//   o_srcsel           : granted source index (data mux select)
//   o_wsel             : word index within the frame
//   o_srload           : one-cycle shift-register load strobe
//   o_latch            : one-cycle output latch strobe at end of frame
//   o_done[1:0]        : one-cycle completion pulse to the served source
import sr_defs::*;

module sr_arbiter #(
  parameter int LENW = 3,
  parameter int GAP  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_req,
  input  logic [LENW-1:0] i_len0,
  input  logic [LENW-1:0] i_len1,
  input  logic            i_srbusy,
  output logic [1:0]      o_gnt,
  output logic            o_srcsel,
  output logic [LENW-1:0] o_wsel,
  output logic            o_srload,
  output logic            o_latch,
  output logic [1:0]      o_done
);

  localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
  localparam int GCW        = (GAP_LAST_I > 0) ? $clog2(GAP_LAST_I + 1) : 1;
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_LAST_I);

  sr_state_e       state_q, state_d;
  logic [LENW-1:0] len_q, len_d;
  logic [GCW-1:0]  gap_q, gap_d;
  logic            last_q, last_d;

  src_vec_t        gnt_d, done_d, arb_gnt;
  logic            srcsel_d, srload_d, latch_d;
  logic [LENW-1:0] wsel_d;

  rr_arb2 u_rr_arb2 (
    .req  (i_req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Every output is computed as the value it must hold in the next state,
  // so the strobes come out of flops aligned with the state they belong to.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    gap_d    = gap_q;
    last_d   = last_q;
    gnt_d    = o_gnt;
    srcsel_d = o_srcsel;
    wsel_d   = o_wsel;
    srload_d = 1'b0;
    latch_d  = 1'b0;
    done_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if ((|i_req) && !i_srbusy) begin
          state_d  = ST_LOAD;
          gnt_d    = arb_gnt;
          srcsel_d = arb_gnt[1];
          len_d    = arb_gnt[1] ? i_len1 : i_len0;
          wsel_d   = '0;
          srload_d = 1'b1;
        end
      end

      ST_LOAD:   state_d = ST_SETTLE;

      // Busy may not have risen yet right after a load, so SETTLE ignores it.
      ST_SETTLE: state_d = ST_WAIT;

      ST_WAIT: begin
        if (!i_srbusy) begin
          if (o_wsel == len_q) begin
            state_d = ST_LATCH;
            latch_d = 1'b1;
            done_d  = src_onehot(o_srcsel);
          end else begin
            state_d  = ST_LOAD;
            wsel_d   = o_wsel + 1'b1;
            srload_d = 1'b1;
          end
        end
      end

      ST_LATCH: begin
        gnt_d   = '0;
        wsel_d  = '0;
        last_d  = o_srcsel;
        gap_d   = '0;
        state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      gap_q    <= '0;
      last_q   <= 1'b1;
      o_gnt    <= '0;
      o_srcsel <= 1'b0;
      o_wsel   <= '0;
      o_srload <= 1'b0;
      o_latch  <= 1'b0;
      o_done   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      last_q   <= last_d;
      o_gnt    <= gnt_d;
      o_srcsel <= srcsel_d;
      o_wsel   <= wsel_d;
      o_srload <= srload_d;
      o_latch  <= latch_d;
      o_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_sr_arbiter.sv
// Self-checking bench for sr_arbiter: a default build (LENW 3, GAP 4) driven
// by directed steps with a scoreboard of load/latch events, and a GAP = 0
// build checked for back-to-back frame timing.
module tb_sr_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [1:0] i_req = '0;
  logic [2:0] i_len0 = '0;
  logic [2:0] i_len1 = '0;
  logic       i_srbusy = 1'b0;
  logic [1:0] o_gnt;
  logic       o_srcsel;
  logic [2:0] o_wsel;
  logic       o_srload;
  logic       o_latch;
  logic [1:0] o_done;

  logic [1:0] z_req = '0;
  logic [2:0] z_len0 = '0;
  logic [2:0] z_len1 = '0;
  logic       z_srbusy = 1'b0;
  logic [1:0] z_gnt;
  logic       z_srcsel;
  logic [2:0] z_wsel;
  logic       z_srload;
  logic       z_latch;
  logic [1:0] z_done;

  int checks = 0;
  int errors = 0;

  bit sr_auto = 1'b0;
  int busy_cycles = 3;

  typedef struct packed {
    logic [1:0] kind;   // 1 = load, 2 = latch
    logic [1:0] gnt;
    logic       srcsel;
    logic [2:0] wsel;
    logic [1:0] done;
  } ev_t;

  ev_t sb[$];

  sr_arbiter #(.LENW(3), .GAP(4)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_len0(i_len0),
    .i_len1(i_len1), .i_srbusy(i_srbusy), .o_gnt(o_gnt),
    .o_srcsel(o_srcsel), .o_wsel(o_wsel), .o_srload(o_srload),
    .o_latch(o_latch), .o_done(o_done)
  );

  sr_arbiter #(.LENW(3), .GAP(0)) u_dut_g0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(z_req), .i_len0(z_len0),
    .i_len1(z_len1), .i_srbusy(z_srbusy), .o_gnt(z_gnt),
    .o_srcsel(z_srcsel), .o_wsel(z_wsel), .o_srload(z_srload),
    .o_latch(z_latch), .o_done(z_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected load/latch events for one frame of len+1 words from src.
  task automatic push_frame(input logic src, input int len);
    logic [1:0] g;
    g = src ? 2'b10 : 2'b01;
    for (int w = 0; w <= len; w++) sb.push_back({2'd1, g, src, 3'(w), 2'b00});
    sb.push_back({2'd2, g, src, 3'(len), g});
  endtask

  task automatic wait_latch(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_latch && n < budget);
    check(tag, o_latch, 1'b1);
  endtask

  task automatic wait_load(input string tag, input logic [2:0] w, input int budget);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(o_srload && o_wsel == w) && n < budget);
    check(tag, {o_srload, o_wsel}, {1'b1, w});
  endtask

  // Shift-register model: busy for busy_cycles after each load strobe.
  initial forever begin
    @(negedge i_clk);
    if (sr_auto && o_srload) begin
      i_srbusy = 1'b1;
      repeat (busy_cycles) @(negedge i_clk);
      i_srbusy = 1'b0;
    end
  end

  // Scoreboard consumer: every strobe the DUT produces must match the queue.
  always @(negedge i_clk) begin
    ev_t got;
    if (!i_rst && (o_srload || o_latch)) begin
      got = {(o_latch ? 2'd2 : 2'd1), o_gnt, o_srcsel, o_wsel, o_done};
      if (sb.size() == 0) check("sb_unexpected_event", got, '0);
      else                check("sb_event", got, sb.pop_front());
    end
  end

  // Load never coincides with latch/done; done pulses exactly with latch.
  always @(negedge i_clk) begin
    check("strobe_overlap", {o_srload & (o_latch | (|o_done)), o_latch ^ (|o_done)}, 2'b00);
    check("strobe_overlap_g0", {z_srload & (z_latch | (|z_done)), z_latch ^ (|z_done)}, 2'b00);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check("reset_outputs", {o_gnt, o_srcsel, o_wsel, o_srload, o_latch, o_done}, '0);
    check("reset_outputs_g0", {z_gnt, z_srcsel, z_wsel, z_srload, z_latch, z_done}, '0);
    i_rst = 1'b0;

    // Three-word frame from source 0 with a busy shift register
    sr_auto = 1'b1;
    busy_cycles = 3;
    i_len0 = 3'd2;
    push_frame(1'b0, 2);
    i_req = 2'b01;
    wait_latch("frame3_latch", 200);
    // Keep requesting: the gap must hold the next grant off.
    i_len0 = 3'd0;
    push_frame(1'b0, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge i_clk);
      check("gap_idle", {o_gnt, o_srload, o_latch, o_done}, '0);
    end
    @(negedge i_clk);
    check("gap_then_grant", {o_gnt, o_srload}, {2'b01, 1'b1});
    i_req = 2'b00;
    wait_latch("len0_latch", 200);
    @(negedge i_clk);
    check("sb_drained_1", sb.size(), 0);

    // Round-robin alternation after reset, both sources requesting
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    sr_auto = 1'b0;
    i_len0 = 3'd0;
    i_len1 = 3'd0;
    push_frame(1'b0, 0);
    push_frame(1'b1, 0);
    push_frame(1'b0, 0);
    push_frame(1'b1, 0);
    i_req = 2'b11;
    for (int f = 0; f < 4; f++) wait_latch("rr_latch", 100);
    i_req = 2'b00;
    repeat (8) @(negedge i_clk);
    check("sb_drained_rr", sb.size(), 0);

    // Busy held in IDLE blocks the grant
    i_srbusy = 1'b1;
    i_req = 2'b10;
    push_frame(1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check("busy_idle_nogrant", o_gnt, 2'b00);
    end
    i_srbusy = 1'b0;
    @(negedge i_clk);
    check("busy_fall_grant", {o_gnt, o_srload}, {2'b10, 1'b1});
    i_req = 2'b00;
    wait_latch("busy_latch", 100);
    repeat (8) @(negedge i_clk);
    check("sb_drained_busy", sb.size(), 0);

    // Max length; length change and request drop mid-frame are ignored
    sr_auto = 1'b1;
    busy_cycles = 1;
    i_len0 = 3'd7;
    push_frame(1'b0, 7);
    i_req = 2'b01;
    wait_load("maxlen_first_load", 3'd0, 50);
    i_len0 = 3'd1;
    i_req = 2'b00;
    wait_latch("maxlen_latch", 200);
    repeat (8) @(negedge i_clk);
    check("sb_drained_maxlen", sb.size(), 0);

    // Reset during WAIT of word 1 aborts the frame
    busy_cycles = 3;
    i_len0 = 3'd2;
    sb.push_back({2'd1, 2'b01, 1'b0, 3'd0, 2'b00});
    sb.push_back({2'd1, 2'b01, 1'b0, 3'd1, 2'b00});
    i_req = 2'b01;
    wait_load("abort_word1_load", 3'd1, 100);
    @(negedge i_clk);  // SETTLE
    @(negedge i_clk);  // WAIT, shift register still busy
    i_rst = 1'b1;
    @(negedge i_clk);
    check("abort_outputs", {o_gnt, o_srcsel, o_wsel, o_srload, o_latch, o_done}, '0);
    i_rst = 1'b0;
    i_req = 2'b00;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_latch || (|o_done)) n++;
    end
    check("abort_no_latch", n, 0);
    check("sb_drained_abort", sb.size(), 0);
    i_len0 = 3'd0;
    i_len1 = 3'd0;
    push_frame(1'b0, 0);
    i_req = 2'b11;
    wait_load("post_abort_grant", 3'd0, 20);
    check("post_abort_src0", o_gnt, 2'b01);
    i_req = 2'b00;
    wait_latch("post_abort_latch", 100);
    repeat (8) @(negedge i_clk);
    check("sb_drained_post_abort", sb.size(), 0);

    // GAP = 0 build: next frame starts the edge after returning to IDLE
    z_len0 = 3'd0;
    z_req = 2'b01;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!z_latch && n < 50);
    check("g0_first_latch", {z_latch, z_done}, {1'b1, 2'b01});
    @(negedge i_clk);
    check("g0_idle", {z_gnt, z_srload, z_latch}, '0);
    @(negedge i_clk);
    check("g0_regrant", {z_gnt, z_srload, z_wsel}, {2'b01, 1'b1, 3'd0});
    repeat (3) @(negedge i_clk);
    check("g0_second_latch", {z_latch, z_done, z_gnt}, {1'b1, 2'b01, 2'b01});
    z_req = 2'b00;
    repeat (4) @(negedge i_clk);

    check("sb_final_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
